// File: rtl/trng_word_buffer_if.sv
// Handshake bundle between trng_word_buffer, the TRNG unit and the entropy consumer.
// The buffer owns the master modport; the TRNG/consumer side uses slave.
interface trng_word_buffer_if #(
   parameter int DEPTH = 4
);
   logic                     trng_request;
   logic [31:0]              trng_word;
   logic                     trng_ready;
   logic                     rnd_valid;
   logic [31:0]              rnd_data;
   logic                     rnd_ready;
   logic                     clear;
   logic                     health_fail;
   logic [$clog2(DEPTH):0]   fill_level;

   modport master (
      output trng_request, rnd_valid, rnd_data, health_fail, fill_level,
      input  trng_word, trng_ready, rnd_ready, clear
   );

   modport slave (
      input  trng_request, rnd_valid, rnd_data, health_fail, fill_level,
      output trng_word, trng_ready, rnd_ready, clear
   );
endinterface

// File: rtl/trng_word_buffer.sv
// Requests words from the TRNG, repetition-tests each one and buffers passing words in a FIFO.
// Optional macro TRNG_STUCK_CHECK_EN: also reject all-zero and all-one words as failures.
module trng_word_buffer #(
   parameter int DEPTH     = 4,
   parameter int REP_LIMIT = 3
) (
   input logic              clk,
   input logic              rst,
   trng_word_buffer_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    REP_C   = 4'(REP_LIMIT);

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic             r_request;

   logic [31:0]      r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;

   logic             r_healthFail;
   logic [3:0]       r_run;
   logic [31:0]      r_prevWord;
   logic             r_prevValid;

   logic             w_capture;
   logic             w_repeat;
   logic [3:0]       w_runNext;
   logic             w_stuck;
   logic             w_fail;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;

`ifdef TRNG_STUCK_CHECK_EN
   assign w_stuck = (bus.trng_word == 32'h0000_0000) || (bus.trng_word == 32'hFFFF_FFFF);
`else
   assign w_stuck = 1'b0;
`endif

   // clear wins over a same-cycle capture, so the word is simply dropped
   assign w_capture = (r_state == REQ) && bus.trng_ready && !bus.clear;
   assign w_repeat  = r_prevValid && (bus.trng_word == r_prevWord);
   assign w_runNext = w_repeat ? (r_run + 4'd1) : 4'd1;
   assign w_fail    = w_capture && ((w_runNext >= REP_C) || w_stuck);
   assign w_push    = w_capture && !w_fail;
   assign w_valid   = (r_count != '0) && !r_healthFail;
   assign w_pop     = w_valid && bus.rnd_ready && !bus.clear;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if ((r_count < DEPTH_C) && !r_healthFail && !bus.clear)
               w_stateNext = REQ;
         end
         REQ: begin
            if (bus.clear || bus.trng_ready)
               w_stateNext = RELEASE;
         end
         RELEASE: begin
            if (!bus.trng_ready)
               w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // trng_request is registered from the next state so it is high exactly while in REQ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_request <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_request <= (w_stateNext == REQ);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (bus.clear || w_fail) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= bus.trng_word;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_pop)
            r_rdPtr <= r_rdPtr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // run is only advanced by stored words; a failing word leaves the alarm latched until clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_healthFail <= 1'b0;
         r_run        <= '0;
         r_prevWord   <= '0;
         r_prevValid  <= 1'b0;
      end else if (bus.clear) begin
         r_healthFail <= 1'b0;
         r_run        <= '0;
         r_prevValid  <= 1'b0;
      end else if (w_fail) begin
         r_healthFail <= 1'b1;
      end else if (w_push) begin
         r_prevWord   <= bus.trng_word;
         r_prevValid  <= 1'b1;
         r_run        <= w_runNext;
      end
   end

   assign bus.trng_request = r_request;
   assign bus.rnd_valid    = w_valid;
   assign bus.rnd_data     = r_mem[r_rdPtr];
   assign bus.health_fail  = r_healthFail;
   assign bus.fill_level   = r_count;
endmodule

// File: tb/tb_trng_word_buffer.sv
// Directed self-checking bench for trng_word_buffer (DEPTH=4, REP_LIMIT=3).
// Honours TRNG_STUCK_CHECK_EN in the stuck-word scenario.
module tb_trng_word_buffer;
   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   trng_word_buffer_if #(.DEPTH(4)) bus ();

   trng_word_buffer #(.DEPTH(4), .REP_LIMIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Acts as the TRNG for one word: waits for a request, delays, then presents the word for one edge
   task automatic serveWord(input logic [31:0] word, output bit ok);
      int n;
      n = 0;
      while (!bus.trng_request && n < 60) begin
         @(negedge clk);
         n++;
      end
      ok = bus.trng_request;
      if (!ok) return;
      repeat (2) @(negedge clk);
      bus.trng_word  = word;
      bus.trng_ready = 1'b1;
      @(negedge clk);
      bus.trng_ready = 1'b0;
   endtask

   task automatic popOne();
      bus.rnd_ready = 1'b1;
      @(negedge clk);
      bus.rnd_ready = 1'b0;
   endtask

   task automatic countRequests(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.trng_request) seen++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      testsRun++; if (bus.trng_request !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_request: got %b expected 0", bus.trng_request); end
      testsRun++; if (bus.rnd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rnd_valid); end
      testsRun++; if (bus.rnd_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 00000000", bus.rnd_data); end
      testsRun++; if (bus.health_fail !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_health: got %b expected 0", bus.health_fail); end
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_fill: got %0d expected 0", bus.fill_level); end
      rst = 1'b0;
   endtask

   task automatic test_handshake();
      bit ok1, ok2;
      serveWord(32'h1234_5678, ok1);
      testsRun++; if (bus.trng_request !== 1'b0) begin testsFailed++; $display("[TB] FAIL req_drop_after_capture: got %b expected 0", bus.trng_request); end
      serveWord(32'h9ABC_DEF0, ok2);
      testsRun++; if (!(ok1 && ok2)) begin testsFailed++; $display("[TB] FAIL handshake_count: got %0d expected 2", int'(ok1) + int'(ok2)); end
      testsRun++; if (bus.fill_level !== 3'd2) begin testsFailed++; $display("[TB] FAIL handshake_fill: got %0d expected 2", bus.fill_level); end
      testsRun++; if (bus.rnd_data !== 32'h1234_5678) begin testsFailed++; $display("[TB] FAIL handshake_head: got %h expected 12345678", bus.rnd_data); end
      testsRun++; if (bus.rnd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL handshake_valid: got %b expected 1", bus.rnd_valid); end
      popOne();
      testsRun++; if (bus.rnd_data !== 32'h9ABC_DEF0) begin testsFailed++; $display("[TB] FAIL pop_head: got %h expected 9abcdef0", bus.rnd_data); end
      testsRun++; if (bus.fill_level !== 3'd1) begin testsFailed++; $display("[TB] FAIL pop_fill: got %0d expected 1", bus.fill_level); end
      popOne();
      testsRun++; if (bus.rnd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_valid: got %b expected 0", bus.rnd_valid); end
   endtask

   task automatic test_fill();
      logic [31:0] words [5];
      logic [31:0] expHead [4];
      bit ok;
      int served, seen;
      words   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
      expHead = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
      served = 0;
      for (int i = 0; i < 4; i++) begin
         serveWord(words[i], ok);
         if (ok) served++;
      end
      testsRun++; if (served !== 4) begin testsFailed++; $display("[TB] FAIL fill_captures: got %0d expected 4", served); end
      testsRun++; if (bus.fill_level !== 3'd4) begin testsFailed++; $display("[TB] FAIL fill_level_full: got %0d expected 4", bus.fill_level); end
      countRequests(20, seen);
      testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL full_no_request: got %0d expected 0", seen); end
      popOne();
      serveWord(words[4], ok);
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL request_after_pop: got %b expected 1", ok); end
      countRequests(20, seen);
      testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL single_refill: got %0d expected 0", seen); end
      for (int i = 0; i < 4; i++) begin
         testsRun++; if (bus.rnd_data !== expHead[i]) begin testsFailed++; $display("[TB] FAIL drain_head%0d: got %h expected %h", i, bus.rnd_data, expHead[i]); end
         popOne();
      end
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL drain_fill: got %0d expected 0", bus.fill_level); end
   endtask

   task automatic test_rep_fail();
      bit ok;
      int seen;
      serveWord(32'hA5A5_A5A5, ok);
      serveWord(32'hA5A5_A5A5, ok);
      testsRun++; if (bus.fill_level !== 3'd2) begin testsFailed++; $display("[TB] FAIL rep_two_stored: got %0d expected 2", bus.fill_level); end
      testsRun++; if (bus.health_fail !== 1'b0) begin testsFailed++; $display("[TB] FAIL rep_no_alarm_yet: got %b expected 0", bus.health_fail); end
      serveWord(32'hA5A5_A5A5, ok);
      testsRun++; if (bus.health_fail !== 1'b1) begin testsFailed++; $display("[TB] FAIL rep_alarm: got %b expected 1", bus.health_fail); end
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL rep_flush: got %0d expected 0", bus.fill_level); end
      testsRun++; if (bus.rnd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rep_valid: got %b expected 0", bus.rnd_valid); end
      countRequests(20, seen);
      testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL alarm_no_request: got %0d expected 0", seen); end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      testsRun++; if (bus.health_fail !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_alarm: got %b expected 0", bus.health_fail); end
      serveWord(32'hA5A5_A5A5, ok);
      testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_resume: got %b expected 1", ok); end
      testsRun++; if (bus.fill_level !== 3'd1) begin testsFailed++; $display("[TB] FAIL clear_run_reset: got %0d expected 1", bus.fill_level); end
      popOne();
   endtask

   task automatic test_clear_capture();
      bit ok;
      int n, seen;
      n = 0;
      while (!bus.trng_request && n < 60) begin @(negedge clk); n++; end
      testsRun++; if (bus.trng_request !== 1'b1) begin testsFailed++; $display("[TB] FAIL clrcap_request: got %b expected 1", bus.trng_request); end
      bus.trng_word  = 32'h5555_AAAA;
      bus.trng_ready = 1'b1;
      bus.clear      = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL clrcap_discard: got %0d expected 0", bus.fill_level); end
      testsRun++; if (bus.trng_request !== 1'b0) begin testsFailed++; $display("[TB] FAIL clrcap_request_low: got %b expected 0", bus.trng_request); end
      countRequests(4, seen);
      testsRun++; if (seen !== 0) begin testsFailed++; $display("[TB] FAIL release_holds: got %0d expected 0", seen); end
      bus.trng_ready = 1'b0;
      serveWord(32'h0F0F_0F0F, ok);
      testsRun++; if (bus.rnd_data !== 32'h0F0F_0F0F) begin testsFailed++; $display("[TB] FAIL clrcap_next_word: got %h expected 0f0f0f0f", bus.rnd_data); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      serveWord(32'h1212_1212, ok);
      serveWord(32'h3434_3434, ok);
      testsRun++; if (bus.fill_level !== 3'd3) begin testsFailed++; $display("[TB] FAIL pre_reset_fill: got %0d expected 3", bus.fill_level); end
      n = 0;
      while (!bus.trng_request && n < 60) begin @(negedge clk); n++; end
      #2 rst = 1'b1;
      #1;
      testsRun++; if (bus.trng_request !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_request: got %b expected 0", bus.trng_request); end
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL async_fill: got %0d expected 0", bus.fill_level); end
      testsRun++; if (bus.rnd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_valid: got %b expected 0", bus.rnd_valid); end
      testsRun++; if (bus.rnd_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL async_data: got %h expected 00000000", bus.rnd_data); end
      @(negedge clk);
      rst = 1'b0;
      serveWord(32'h7777_1234, ok);
      testsRun++; if (bus.fill_level !== 3'd1) begin testsFailed++; $display("[TB] FAIL post_reset_fill: got %0d expected 1", bus.fill_level); end
      testsRun++; if (bus.rnd_data !== 32'h7777_1234) begin testsFailed++; $display("[TB] FAIL post_reset_head: got %h expected 77771234", bus.rnd_data); end
   endtask

   task automatic test_stuck();
      bit ok;
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      serveWord(32'h0000_0000, ok);
`ifdef TRNG_STUCK_CHECK_EN
      testsRun++; if (bus.health_fail !== 1'b1) begin testsFailed++; $display("[TB] FAIL stuck_alarm: got %b expected 1", bus.health_fail); end
      testsRun++; if (bus.fill_level !== 3'd0) begin testsFailed++; $display("[TB] FAIL stuck_fill: got %0d expected 0", bus.fill_level); end
`else
      testsRun++; if (bus.health_fail !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_no_alarm: got %b expected 0", bus.health_fail); end
      testsRun++; if (bus.fill_level !== 3'd1) begin testsFailed++; $display("[TB] FAIL zero_stored: got %0d expected 1", bus.fill_level); end
`endif
   endtask

   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      rst            = 1'b1;
      bus.trng_word  = '0;
      bus.trng_ready = 1'b0;
      bus.rnd_ready  = 1'b0;
      bus.clear      = 1'b0;
      @(negedge clk);
      test_reset();
      test_handshake();
      test_fill();
      test_rep_fail();
      test_clear_capture();
      test_reset_mid();
      test_stuck();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
